// File: rtl/cas_ctrl_pkg.sv
// Shared types for the CAS-Lock oracle sequencer.
// Controller states and default core widths.
package cas_ctrl_pkg;

  localparam int KEY_W_D = 64;
  localparam int IN_W_D  = 41;

  typedef enum logic [2:0] {
    S_LOAD,
    S_READY,
    S_SETTLE,
    S_RESP,
    S_LOCKOUT
  } state_t;

endpackage

// File: rtl/cas_oracle_sequencer_if.sv
// Query/response channel of the oracle sequencer.
// master: q_valid/q_data/r_ready out; slave: q_ready/r_valid/r_data out.
interface cas_oracle_sequencer_if #(
  parameter int IN_W  = 41,
  parameter int OUT_W = 1
);

  logic             q_valid;
  logic [IN_W-1:0]  q_data;
  logic             q_ready;
  logic             r_valid;
  logic [OUT_W-1:0] r_data;
  logic             r_ready;

  modport master (
    output q_valid, q_data, r_ready,
    input  q_ready, r_valid, r_data
  );

  modport slave (
    input  q_valid, q_data, r_ready,
    output q_ready, r_valid, r_data
  );

endinterface

// File: rtl/cas_key_shifter.sv
// Serial key loader: shadow register, bit counter, atomic copy to keyinput.
// Ports: clk, rst_n, clr, bit_en, bit_data in; last, keyinput, key_loaded out.
module cas_key_shifter
  import cas_ctrl_pkg::*;
#(
  parameter int KEY_W = KEY_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_data,
  output logic             last,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_loaded
);

  localparam int CW = $clog2(KEY_W);

  logic [KEY_W-1:0] shadow;
  logic [KEY_W-1:0] shadow_nx;
  logic [CW-1:0]    cnt;

  assign last = bit_en && (cnt == CW'(KEY_W - 1));

  // Final bit is merged here so keyinput gets the whole key in one edge.
  always_comb begin
    shadow_nx      = shadow;
    shadow_nx[cnt] = bit_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      shadow     <= '0;
      cnt        <= '0;
      keyinput   <= '0;
      key_loaded <= 1'b0;
    end else if (bit_en) begin
      shadow <= shadow_nx;
      if (last) begin
        keyinput   <= shadow_nx;
        key_loaded <= 1'b1;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cas_oracle_sequencer.sv
// Key loader and oracle query sequencer for a CAS-Lock locked core.
// Ports: clk, rst_n, kb_*, key_reload, keyinput, core_in/out, query_count,
// lockout, qif (query/response). Macro CAS_QUERY_LIMIT_EN adds LOCKOUT.
module cas_oracle_sequencer
  import cas_ctrl_pkg::*;
#(
  parameter int KEY_W  = KEY_W_D,
  parameter int IN_W   = IN_W_D,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 2,
  parameter int QCNT_W = 16,
  parameter int MAX_Q  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kb_valid,
  input  logic              kb_data,
  output logic              kb_ready,
  input  logic              key_reload,
  output logic              key_loaded,
  output logic [KEY_W-1:0]  keyinput,
  output logic [IN_W-1:0]   core_in,
  input  logic [OUT_W-1:0]  core_out,
  output logic [QCNT_W-1:0] query_count,
  output logic              lockout,
  cas_oracle_sequencer_if.slave qif
);

  if (SETTLE < 1 || SETTLE > 15 ||
      MAX_Q >= (1 << QCNT_W)) begin : g_bad_params
    $error("cas_oracle_sequencer: illegal SETTLE or MAX_Q");
  end

  state_t           state;
  state_t           state_nx;
  logic [3:0]       scnt;
  logic [OUT_W-1:0] r_data_q;

  logic in_load, in_ready, in_settle, in_resp;
  logic reload_ok, kb_acc, q_acc;
  logic settle_done, resp_hs, to_lock, key_clr;
  logic key_last;

  assign in_load   = (state == S_LOAD);
  assign in_ready  = (state == S_READY);
  assign in_settle = (state == S_SETTLE);
  assign in_resp   = (state == S_RESP);

  // Reload beats any simultaneous key bit or query accept.
  assign reload_ok = key_reload & (in_load | in_ready);
  assign kb_acc    = kb_valid & in_load & ~key_reload;
  assign q_acc     = qif.q_valid & in_ready & ~key_reload;

  assign settle_done = in_settle && (scnt == 4'(SETTLE - 1));
  assign resp_hs     = in_resp & qif.r_ready;

`ifdef CAS_QUERY_LIMIT_EN
  assign to_lock = resp_hs && (query_count == QCNT_W'(MAX_Q));
  assign lockout = (state == S_LOCKOUT);
`else
  assign to_lock = 1'b0;
  assign lockout = 1'b0;
`endif

  assign key_clr = reload_ok | to_lock;

  assign kb_ready    = in_load;
  assign qif.q_ready = in_ready;
  assign qif.r_valid = in_resp;
  assign qif.r_data  = r_data_q;

  cas_key_shifter #(.KEY_W(KEY_W)) u_key (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (key_clr),
    .bit_en     (kb_acc),
    .bit_data   (kb_data),
    .last       (key_last),
    .keyinput   (keyinput),
    .key_loaded (key_loaded)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD: begin
        if (reload_ok)     state_nx = S_LOAD;
        else if (key_last) state_nx = S_READY;
      end
      S_READY: begin
        if (reload_ok)  state_nx = S_LOAD;
        else if (q_acc) state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_done) state_nx = S_RESP;
      end
      S_RESP: begin
        if (to_lock)      state_nx = S_LOCKOUT;
        else if (resp_hs) state_nx = S_READY;
      end
      S_LOCKOUT: state_nx = S_LOCKOUT;
      default:   state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_LOAD;
      scnt        <= '0;
      core_in     <= '0;
      r_data_q    <= '0;
      query_count <= '0;
    end else begin
      state <= state_nx;
      if (q_acc) begin
        core_in <= qif.q_data;
        scnt    <= '0;
      end else if (in_settle) begin
        scnt <= scnt + 1'b1;
      end
      if (settle_done) begin
        r_data_q <= core_out;
        if (query_count != '1)
          query_count <= query_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cas_oracle_sequencer.sv
// Directed + randomized bench for cas_oracle_sequencer.
// Oracle model: out = ^(pattern & key[IN_W-1:0]) ^ key[KEY_W-1].
module tb_cas_oracle_sequencer;

  localparam int KEY_W  = 64;
  localparam int IN_W   = 41;
  localparam int OUT_W  = 1;
  localparam int SETTLE = 2;
  localparam int QCNT_W = 16;
  localparam int MAX_Q  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              kb_valid = 1'b0;
  logic              kb_data = 1'b0;
  logic              key_reload = 1'b0;
  logic              kb_ready;
  logic              key_loaded;
  logic [KEY_W-1:0]  keyinput;
  logic [IN_W-1:0]   core_in;
  logic [OUT_W-1:0]  core_out;
  logic [QCNT_W-1:0] query_count;
  logic              lockout;

  int checks = 0;
  int errors = 0;
  logic [63:0] cur_key = '0;
  int exp_q = 0;

  cas_oracle_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) qif ();

  always #5 clk = ~clk;

  // Stand-in locked core, driven by the DUT's own key and pattern buses.
  assign core_out = ^(core_in & keyinput[IN_W-1:0]) ^ keyinput[KEY_W-1];

  cas_oracle_sequencer #(
    .KEY_W(KEY_W), .IN_W(IN_W), .OUT_W(OUT_W),
    .SETTLE(SETTLE), .QCNT_W(QCNT_W), .MAX_Q(MAX_Q)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .kb_valid    (kb_valid),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .key_reload  (key_reload),
    .key_loaded  (key_loaded),
    .keyinput    (keyinput),
    .core_in     (core_in),
    .core_out    (core_out),
    .query_count (query_count),
    .lockout     (lockout),
    .qif         (qif.slave)
  );

  function automatic logic oracle(logic [IN_W-1:0] p, logic [63:0] k);
    return ^(p & k[IN_W-1:0]) ^ k[63];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    kb_valid = 1'b0;
    key_reload = 1'b0;
    qif.q_valid = 1'b0;
    qif.r_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_q = 0;
    cur_key = '0;
  endtask

  task automatic check_reset();
    check("rst_kb_ready", 64'(kb_ready), 64'd1);
    check("rst_key_loaded", 64'(key_loaded), 64'd0);
    check("rst_keyinput", keyinput, 64'd0);
    check("rst_q_ready", 64'(qif.q_ready), 64'd0);
    check("rst_r_valid", 64'(qif.r_valid), 64'd0);
    check("rst_r_data", 64'(qif.r_data), 64'd0);
    check("rst_core_in", 64'(core_in), 64'd0);
    check("rst_qcount", 64'(query_count), 64'd0);
    check("rst_lockout", 64'(lockout), 64'd0);
  endtask

  task automatic load_key(input logic [63:0] k);
    for (int i = 0; i < KEY_W; i++) begin
      kb_valid = 1'b1;
      kb_data  = k[i];
      if (i == KEY_W - 1) begin
        check("partial_loaded", 64'(key_loaded), 64'd0);
        check("partial_key", keyinput, 64'd0);
      end
      step();
    end
    kb_valid = 1'b0;
    cur_key = k;
    check("key_loaded", 64'(key_loaded), 64'd1);
    check("keyinput", keyinput, k);
    check("kb_ready_done", 64'(kb_ready), 64'd0);
    check("q_ready_after_key", 64'(qif.q_ready), 64'd1);
  endtask

  task automatic query(input logic [IN_W-1:0] p, input int hold,
                       input bit reload_settle);
    int lat;
    logic [OUT_W-1:0] exp_r;
    check("q_ready_pre", 64'(qif.q_ready), 64'd1);
    qif.q_valid = 1'b1;
    qif.q_data  = p;
    step();
    qif.q_valid = 1'b0;
    check("core_in_acc", 64'(core_in), 64'(p));
    check("q_ready_settle", 64'(qif.q_ready), 64'd0);
    lat = 0;
    while (qif.r_valid !== 1'b1 && lat < 20) begin
      key_reload = reload_settle && (lat == 0);
      step();
      key_reload = 1'b0;
      lat++;
    end
    check("latency", 64'(lat), 64'(SETTLE));
    exp_r = oracle(p, cur_key);
    if (exp_q < (1 << QCNT_W) - 1) exp_q++;
    check("r_data", 64'(qif.r_data), 64'(exp_r));
    check("qcount", 64'(query_count), 64'(exp_q));
    check("key_kept", keyinput, cur_key);
    check("core_in_held", 64'(core_in), 64'(p));
    for (int h = 0; h < hold; h++) begin
      qif.q_valid = 1'b1;
      qif.q_data  = ~p;
      step();
      check("hold_r_valid", 64'(qif.r_valid), 64'd1);
      check("hold_r_data", 64'(qif.r_data), 64'(exp_r));
      check("hold_q_ready", 64'(qif.q_ready), 64'd0);
      check("hold_core_in", 64'(core_in), 64'(p));
    end
    qif.q_valid = 1'b0;
    qif.r_ready = 1'b1;
    step();
    qif.r_ready = 1'b0;
    check("r_valid_drop", 64'(qif.r_valid), 64'd0);
`ifdef CAS_QUERY_LIMIT_EN
    if (exp_q == MAX_Q) begin
      check("lockout", 64'(lockout), 64'd1);
      check("lock_key", keyinput, 64'd0);
      check("lock_q_ready", 64'(qif.q_ready), 64'd0);
      check("lock_kb_ready", 64'(kb_ready), 64'd0);
    end else begin
      check("q_ready_back", 64'(qif.q_ready), 64'd1);
    end
`else
    check("q_ready_back", 64'(qif.q_ready), 64'd1);
    check("no_lockout", 64'(lockout), 64'd0);
`endif
    check("core_in_kept", 64'(core_in), 64'(p));
  endtask

  logic [IN_W-1:0] pat;
  logic [63:0] rkey;
  logic [IN_W-1:0] prev_in;

  initial begin
    qif.q_valid = 1'b0;
    qif.q_data  = '0;
    qif.r_ready = 1'b0;
    do_reset();
    check_reset();

    // 30 bits, then reload with a bit offered the same cycle.
    for (int i = 0; i < 30; i++) begin
      kb_valid = 1'b1;
      kb_data  = 1'($urandom());
      step();
    end
    check("p30_key", keyinput, 64'd0);
    check("p30_loaded", 64'(key_loaded), 64'd0);
    key_reload = 1'b1;
    kb_data = 1'b1;
    step();
    key_reload = 1'b0;
    kb_valid = 1'b0;
    check("reload_kb_ready", 64'(kb_ready), 64'd1);
    load_key(64'hA5A5_0000_FFFF_1234);

    // Stray key bits in READY are ignored.
    kb_valid = 1'b1;
    kb_data = 1'b0;
    repeat (3) step();
    kb_valid = 1'b0;
    check("stray_key", keyinput, cur_key);
    check("stray_q_ready", 64'(qif.q_ready), 64'd1);

    query(41'h1_2345_6789A, 5, 1'b0);
    pat = IN_W'({$urandom(), $urandom()});
    query(pat, 0, 1'b1);
    check("reload_settle_loaded", 64'(key_loaded), 64'd1);
    pat = IN_W'({$urandom(), $urandom()});
    query(pat, 1, 1'b0);

`ifdef CAS_QUERY_LIMIT_EN
    key_reload = 1'b1;
    qif.q_valid = 1'b1;
    step();
    key_reload = 1'b0;
    step();
    qif.q_valid = 1'b0;
    check("lock_stays", 64'(lockout), 64'd1);
    check("lock_key_stays", keyinput, 64'd0);
    check("lock_qcount", 64'(query_count), 64'(MAX_Q));
    do_reset();
    check_reset();
    rkey = {$urandom(), $urandom()};
    load_key(rkey);
`else
    for (int i = 0; i < 4; i++) begin
      pat = IN_W'({$urandom(), $urandom()});
      query(pat, int'($urandom_range(0, 2)), 1'b0);
    end
`endif

    // Reload in READY beats a simultaneous query.
    prev_in = core_in;
    qif.q_valid = 1'b1;
    qif.q_data = ~prev_in;
    key_reload = 1'b1;
    step();
    key_reload = 1'b0;
    qif.q_valid = 1'b0;
    check("rr_kb_ready", 64'(kb_ready), 64'd1);
    check("rr_q_ready", 64'(qif.q_ready), 64'd0);
    check("rr_loaded", 64'(key_loaded), 64'd0);
    check("rr_key", keyinput, 64'd0);
    check("rr_core_in", 64'(core_in), 64'(prev_in));
    check("rr_qcount", 64'(query_count), 64'(exp_q));

    rkey = {$urandom(), $urandom()};
    load_key(rkey);
    pat = IN_W'({$urandom(), $urandom()});
    query(pat, 0, 1'b0);

    // Reset while a query is settling.
    qif.q_valid = 1'b1;
    qif.q_data = IN_W'({$urandom(), $urandom()});
    step();
    qif.q_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    exp_q = 0;
    check_reset();
    rst_n = 1'b1;
    step();
    check_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
